// File: rtl/latch_bus_reader_if.sv
// Bundle of scan-control, latch-bus and read-out signals for latch_bus_reader.
// Latency: none; the interface only carries wires between the reader and its environment.
// Backpressure: rd_ready stalls the reader, which keeps the bus released meanwhile.
interface latch_bus_reader_if #(
   parameter int NUM_DEV = 4,
   parameter int DEV_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
);
   logic               start;
   logic               le;
   logic [NUM_DEV-1:0] oe_n;
   logic [7:0]         bus_in;
   logic [7:0]         rd_data;
   logic [DEV_W-1:0]   rd_dev;
   logic               rd_valid;
   logic               rd_ready;
   logic               busy;
   logic               done;

   // Reader side: owns the latch controls and the read-out stream.
   modport master (
      input  start, bus_in, rd_ready,
      output le, oe_n, rd_data, rd_dev, rd_valid, busy, done
   );

   // Environment side: devices on the bus plus the downstream consumer.
   modport slave (
      output start, bus_in, rd_ready,
      input  le, oe_n, rd_data, rd_dev, rd_valid, busy, done
   );
endinterface

// File: rtl/latch_bus_reader.sv
// Scans a bank of octal transparent latches on a shared byte bus and streams each byte out.
// Latency: le in cycle 1 after start, first byte valid in cycle 2+SETUP_CYC, done at 2+N*(SETUP+1)+(N-1)*GAP.
// Backpressure: rd_ready low holds the byte in SEND with every oe_n high; each stall cycle delays the scan by one.
module latch_bus_reader #(
   parameter int NUM_DEV   = 4,
   parameter int SETUP_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   latch_bus_reader_if.master bus
);
   localparam int DEV_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
   localparam int CNT_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [DEV_W-1:0] LAST_IDX   = DEV_W'(NUM_DEV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   // GAP is unreachable when GAP_CYC is 0, so the clamp only keeps the constant legal.
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      ENABLE = 3'd2,
      SEND   = 3'd3,
      GAP    = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t             state, state_nx;
   logic [DEV_W-1:0]   idx, idx_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               cap;
   logic               le_nx;
   logic [NUM_DEV-1:0] oe_n_nx;
   logic               rd_valid_nx;
   logic               busy_nx;
   logic               done_nx;

   // Next-state sequencing; every output is then derived from the state being entered,
   // so the registered outputs line up with the state they describe.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      cap      = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) state_nx = LATCH;
         end
         LATCH: begin
            state_nx = ENABLE;
            cnt_nx   = '0;
         end
         ENABLE: begin
            if (cnt == SETUP_LAST) begin
               state_nx = SEND;
               cap      = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         SEND: begin
            if (bus.rd_valid && bus.rd_ready) begin
               if (idx == LAST_IDX) begin
                  state_nx = DONE;
               end else if (GAP_CYC > 0) begin
                  state_nx = GAP;
                  cnt_nx   = '0;
               end else begin
                  idx_nx   = idx + 1'b1;
                  state_nx = ENABLE;
                  cnt_nx   = '0;
               end
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               idx_nx   = idx + 1'b1;
               state_nx = ENABLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE: begin
            idx_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // Only ENABLE drives a device onto the bus, and only one device at a time.
      le_nx       = (state_nx == LATCH);
      oe_n_nx     = (state_nx == ENABLE) ? ~(NUM_DEV'(1) << idx_nx) : '1;
      rd_valid_nx = (state_nx == SEND);
      busy_nx     = (state_nx != IDLE);
      done_nx     = (state_nx == DONE);
   end

   // State, counters and registered outputs; reset drops any partial scan immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         cnt          <= '0;
         bus.le       <= 1'b0;
         bus.oe_n     <= '1;
         bus.rd_data  <= 8'h00;
         bus.rd_dev   <= '0;
         bus.rd_valid <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         state        <= state_nx;
         idx          <= idx_nx;
         cnt          <= cnt_nx;
         bus.le       <= le_nx;
         bus.oe_n     <= oe_n_nx;
         bus.rd_valid <= rd_valid_nx;
         bus.busy     <= busy_nx;
         bus.done     <= done_nx;
         if (cap) begin
            bus.rd_data <= bus.bus_in;
            bus.rd_dev  <= idx;
         end
      end
   end
endmodule

// File: tb/tb_latch_bus_reader.sv
// Bench for latch_bus_reader: table of directed scans, randomized scans, reset and edge-parameter cases.
// Latency: expectations are computed from the cycle formula plus the number of observed stall cycles.
// Backpressure: rd_ready is stalled on demand or at random; stalled bytes must stay stable with the bus released.
module tb_latch_bus_reader;
   localparam int N = 4;
   localparam int S = 2;
   localparam int G = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   latch_bus_reader_if #(.NUM_DEV(4)) d_if ();
   latch_bus_reader_if #(.NUM_DEV(1)) e_if ();

   latch_bus_reader #(.NUM_DEV(4), .SETUP_CYC(2), .GAP_CYC(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (d_if)
   );

   latch_bus_reader #(.NUM_DEV(1), .SETUP_CYC(1), .GAP_CYC(0)) dut_e (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (e_if)
   );

   int checks = 0;
   int errors = 0;
   bit running = 1'b1;

   // Device models: transparent while le is high, frozen otherwise.
   logic [3:0][7:0] dev_in;
   logic [3:0][7:0] latch_q;
   logic [7:0]      e_dev_in;
   logic [7:0]      e_latch;

   always @(d_if.le or dev_in) if (d_if.le) latch_q = dev_in;
   always @(e_if.le or e_dev_in) if (e_if.le) e_latch = e_dev_in;

   // Released bus reads as a recognisable filler value.
   always_comb begin
      d_if.bus_in = 8'hEE;
      for (int i = 0; i < 4; i++) if (!d_if.oe_n[i]) d_if.bus_in = latch_q[i];
   end
   always_comb e_if.bus_in = e_if.oe_n[0] ? 8'hEE : e_latch;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Bus contention checker for both readers on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n && running) begin
         checks++;
         if (!$onehot0(~d_if.oe_n) || (d_if.le && (d_if.oe_n != 4'hF)) ||
             (e_if.le && !e_if.oe_n[0])) begin
            errors++;
            $display("FAIL bus_invariant le=%0b oe_n=%b e_le=%0b e_oe_n=%b required one-hot-or-none oe low and none with le",
                     d_if.le, d_if.oe_n, e_if.le, e_if.oe_n);
         end
      end
   end

   typedef struct {
      logic [3:0][7:0] vals;
      int              stall_dev;
      int              stall_len;
      bit              snap;
      bit              noise;
      int              exp_done;
   } vec_t;

   // One full scan; entered and left at #1 after a rising edge with the reader idle.
   task automatic run_scan(input logic [3:0][7:0] vals, input int stall_dev, input int stall_len,
                           input bit snap, input bit noise, input bit rnd_ready,
                           input int exp_done, input string tag);
      int c = 0;
      int stalls = 0;
      int nbytes = 0;
      int stall_left = stall_len;
      int base = 2 + N * (S + 1) + (N - 1) * G;
      bit in_send = 1'b0;
      bit got_done = 1'b0;
      bit rdy;
      logic [7:0] held = 8'h00;
      logic [3:0][7:0] exp_vals = vals;

      dev_in        = vals;
      chk({tag, " le_c0"}, 32'(d_if.le), 32'd0);
      d_if.start    = 1'b1;
      d_if.rd_ready = 1'b1;
      while (!got_done && c < 200) begin
         @(posedge clk);
         #1;
         c++;
         d_if.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (snap && c == 2) dev_in = '1;
         chk({tag, " le"}, 32'(d_if.le), 32'(c == 1));
         if (c >= 2 && c <= 1 + S) chk({tag, " oe_n_dev0"}, 32'(d_if.oe_n), 32'hE);
         if (d_if.rd_valid) begin
            if (!in_send) begin
               chk({tag, " valid_cycle"}, 32'(c), 32'(2 + S + nbytes * (S + 1 + G) + stalls));
               chk({tag, " rd_dev"}, 32'(d_if.rd_dev), 32'(nbytes));
               if (nbytes < N) chk({tag, " rd_data"}, 32'(d_if.rd_data), 32'(exp_vals[nbytes]));
               held    = d_if.rd_data;
               in_send = 1'b1;
            end else begin
               chk({tag, " stall_data"}, 32'(d_if.rd_data), 32'(held));
               chk({tag, " stall_oe_n"}, 32'(d_if.oe_n), 32'hF);
            end
            if (rnd_ready) begin
               rdy = ($urandom_range(0, 3) != 0);
            end else if (nbytes == stall_dev && stall_left > 0) begin
               rdy = 1'b0;
               stall_left--;
            end else begin
               rdy = 1'b1;
            end
            d_if.rd_ready = rdy;
            if (rdy) begin
               nbytes++;
               in_send = 1'b0;
            end else begin
               stalls++;
            end
         end else begin
            d_if.rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (d_if.done) begin
            got_done = 1'b1;
            chk({tag, " done_cycle"}, 32'(c), 32'(base + stalls));
            if (exp_done >= 0) chk({tag, " done_table"}, 32'(c), 32'(exp_done));
            chk({tag, " byte_count"}, 32'(nbytes), 32'(N));
         end
      end
      if (!got_done) begin
         errors++;
         $display("FAIL %s timeout actual=no done required=done by cycle 200", tag);
      end
      d_if.start    = 1'b0;
      d_if.rd_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, " busy_after"}, 32'(d_if.busy), 32'd0);
      chk({tag, " valid_after"}, 32'(d_if.rd_valid), 32'd0);
      chk({tag, " rd_data_kept"}, 32'(d_if.rd_data), 32'(exp_vals[N-1]));
   endtask

   vec_t vecs [4];

   initial begin
      int c;
      bit seen;
      logic [17:0] rst_vec = {1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};

      vecs[0] = '{vals: {8'hD4, 8'hC3, 8'hB2, 8'hA1}, stall_dev: -1, stall_len: 0, snap: 0, noise: 0, exp_done: 17};
      vecs[1] = '{vals: {8'hD4, 8'hC3, 8'hB2, 8'hA1}, stall_dev: -1, stall_len: 0, snap: 1, noise: 0, exp_done: 17};
      vecs[2] = '{vals: {8'hD4, 8'hC3, 8'hB2, 8'hA1}, stall_dev: 1,  stall_len: 5, snap: 0, noise: 0, exp_done: 22};
      vecs[3] = '{vals: {8'hD4, 8'hC3, 8'hB2, 8'hA1}, stall_dev: -1, stall_len: 0, snap: 1, noise: 1, exp_done: 17};

      rst_n         = 1'b0;
      d_if.start    = 1'b0;
      d_if.rd_ready = 1'b1;
      e_if.start    = 1'b0;
      e_if.rd_ready = 1'b1;
      dev_in        = '0;
      e_dev_in      = 8'h00;

      #22;
      chk("reset_outputs", 32'({d_if.le, d_if.oe_n, d_if.rd_valid, d_if.busy, d_if.done, d_if.rd_data, d_if.rd_dev}),
          32'(rst_vec));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle with start low: nothing may move.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("idle_outputs", 32'({d_if.le, d_if.oe_n, d_if.rd_valid, d_if.busy, d_if.done, d_if.rd_data, d_if.rd_dev}),
             32'(rst_vec));
      end

      // Reset in the middle of the first ENABLE window.
      dev_in     = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      d_if.start = 1'b1;
      @(posedge clk);
      #1;
      d_if.start = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_reset_oe_n", 32'(d_if.oe_n), 32'hE);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midscan_reset", 32'({d_if.oe_n, d_if.le, d_if.rd_valid, d_if.busy}), 32'({4'hF, 1'b0, 1'b0, 1'b0}));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < 4; v++)
         run_scan(vecs[v].vals, vecs[v].stall_dev, vecs[v].stall_len, vecs[v].snap, vecs[v].noise, 1'b0,
                  vecs[v].exp_done, $sformatf("vec%0d", v));

      for (int r = 0; r < 6; r++)
         run_scan({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, -1, 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, -1, $sformatf("rnd%0d", r));

      // Single-device reader with a one-cycle setup window and no gap.
      e_dev_in   = 8'h3C;
      e_if.start = 1'b1;
      c          = 0;
      seen       = 1'b0;
      while (!seen && c < 50) begin
         @(posedge clk);
         #1;
         c++;
         e_if.start = 1'b0;
         if (c == 2) e_dev_in = 8'h00;
         if (e_if.rd_valid) begin
            chk("edge_valid_cycle", 32'(c), 32'd3);
            chk("edge_rd_data", 32'(e_if.rd_data), 32'h3C);
            chk("edge_rd_dev", 32'(e_if.rd_dev), 32'd0);
         end
         if (e_if.done) begin
            seen = 1'b1;
            chk("edge_done_cycle", 32'(c), 32'd4);
         end
      end
      if (!seen) begin
         errors++;
         $display("FAIL edge_timeout actual=no done required=done in cycle 4");
      end
      @(posedge clk);
      #1;
      chk("edge_busy_after", 32'(e_if.busy), 32'd0);

      running = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
